// File: rtl/riscv_wb_pkg.sv
// Shared write-back definitions: result-source encodings, load funct3 codes,
// the buffered entry layout and the load alignment/extension helper.
package riscv_wb_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } ld_res_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] data;
    logic            err;
  } wb_entry_t;

  function automatic ld_res_t load_align(input logic [XLEN-1:0] word,
                                         input logic [2:0]      f3,
                                         input logic [1:0]      off);
    ld_res_t     res;
    logic [7:0]  b;
    logic [15:0] h;
    b        = word[{off, 3'b000} +: 8];
    h        = off[1] ? word[31:16] : word[15:0];
    res.data = '0;
    res.err  = 1'b0;
    case (f3)
      F3_LB:  res.data = {{24{b[7]}}, b};
      F3_LBU: res.data = {24'd0, b};
      F3_LH: begin
        if (off[0]) res.err  = 1'b1;
        else        res.data = {{16{h[15]}}, h};
      end
      F3_LHU: begin
        if (off[0]) res.err  = 1'b1;
        else        res.data = {16'd0, h};
      end
      F3_LW: begin
        if (off != 2'b00) res.err  = 1'b1;
        else              res.data = word;
      end
      default: res.err = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// DEPTH-entry in-order buffer; the incoming entry is visible at the head
// (pass-through) when the buffer is empty.
module wb_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_s;
  logic          store_s;
  logic          take_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign empty_s    = (count_r == '0);
  assign head_valid = ~empty_s | push;
  assign head_data  = empty_s ? push_data : mem_r[rd_ptr_r];
  // A push that is consumed the same cycle on an empty buffer bypasses storage.
  assign store_s    = push & ~(empty_s & pop);
  assign take_s     = pop & ~empty_s;
  assign count      = count_r;

  // Storage array write.
  always_ff @(posedge clk) begin
    if (store_s) mem_r[wr_ptr_r] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (store_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (take_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({store_s, take_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// RISC-V write-back stage: resolves the result at accept, buffers under hold,
// and drives the register bank write port. Optional retire counter: WB_INSTRET_EN.
module wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int INSTRET_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rd,
  input  logic                 in_rd_we,
  input  logic [1:0]           in_wb_sel,
  input  logic [XLEN-1:0]      in_alu,
  input  logic [XLEN-1:0]      in_pc4,
  input  logic [XLEN-1:0]      in_ld_data,
  input  logic [2:0]           in_ld_f3,
  input  logic [1:0]           in_ld_off,
  input  logic                 hold,
  output logic                 reg_wr,
  output logic [4:0]           dir_wr,
  output logic [XLEN-1:0]      di,
  output logic                 err_load
`ifdef WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ld_res_t       ld_res_s;
  wb_entry_t     new_entry_s;
  wb_entry_t     head_s;
  logic          head_valid_s;
  logic [CW-1:0] count_s;
  logic          push_s;
  logic          pop_s;
  logic          write_s;

  // Result selection and load extraction for the incoming instruction.
  always_comb begin
    ld_res_s         = load_align(in_ld_data, in_ld_f3, in_ld_off);
    new_entry_s.rd   = in_rd;
    new_entry_s.we   = 1'b0;
    new_entry_s.data = '0;
    new_entry_s.err  = 1'b0;
    case (in_wb_sel)
      WB_ALU: begin
        new_entry_s.we   = in_rd_we;
        new_entry_s.data = in_alu;
      end
      WB_LOAD: begin
        new_entry_s.we   = in_rd_we;
        new_entry_s.data = ld_res_s.data;
        new_entry_s.err  = ld_res_s.err;
      end
      WB_PC4: begin
        new_entry_s.we   = in_rd_we;
        new_entry_s.data = in_pc4;
      end
      default: begin
        new_entry_s.we   = 1'b0;
        new_entry_s.data = '0;
      end
    endcase
  end

  assign in_ready = (count_s < CW'(FIFO_DEPTH));
  assign push_s   = in_valid & in_ready;
  assign pop_s    = ~hold & head_valid_s;
  assign write_s  = head_s.we & ~head_s.err & (head_s.rd != 5'd0);

  wb_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wb_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_data  (new_entry_s),
    .pop        (pop_s),
    .head_valid (head_valid_s),
    .head_data  (head_s),
    .count      (count_s)
  );

  // Register bank write port; address and data hold when no write issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr   <= 1'b0;
      dir_wr   <= 5'd0;
      di       <= '0;
      err_load <= 1'b0;
    end else if (pop_s) begin
      reg_wr   <= write_s;
      err_load <= head_s.err;
      if (write_s) begin
        dir_wr <= head_s.rd;
        di     <= head_s.data;
      end
    end else begin
      reg_wr   <= 1'b0;
      err_load <= 1'b0;
    end
  end

`ifdef WB_INSTRET_EN
  // Retire counter: every error-free issue counts, including x0/no-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (pop_s && !head_s.err) begin
      instret <= instret + INSTRET_W'(1);
    end else begin
      instret <= instret;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected retire events are queued at accept
// and compared by a negedge monitor as write/error pulses appear.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic [31:0] in_ld_data;
  logic [2:0]  in_ld_f3;
  logic [1:0]  in_ld_off;
  logic        hold;
  logic        reg_wr;
  logic [4:0]  dir_wr;
  logic [31:0] di;
  logic        err_load;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] ir_snap;
`endif

  typedef struct {
    bit          is_err;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int K_WRITE  = 0;
  localparam int K_ERR    = 1;
  localparam int K_SILENT = 2;

  wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .in_wb_sel  (in_wb_sel),
    .in_alu     (in_alu),
    .in_pc4     (in_pc4),
    .in_ld_data (in_ld_data),
    .in_ld_f3   (in_ld_f3),
    .in_ld_off  (in_ld_off),
    .hold       (hold),
    .reg_wr     (reg_wr),
    .dir_wr     (dir_wr),
    .di         (di),
    .err_load   (err_load)
`ifdef WB_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (reg_wr === 1'b1 || err_load === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retire reg_wr=%b err_load=%b dir_wr=%0d di=%h",
                 reg_wr, err_load, dir_wr, di);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_err) begin
          if (err_load !== 1'b1 || reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL sb_err got reg_wr=%b err_load=%b want reg_wr=0 err_load=1",
                     reg_wr, err_load);
          end
        end else if (reg_wr !== 1'b1 || err_load !== 1'b0 || dir_wr !== e.rd || di !== e.data) begin
          errors++;
          $display("FAIL sb_write got wr=%b err=%b rd=%0d di=%h want wr=1 err=0 rd=%0d di=%h",
                   reg_wr, err_load, dir_wr, di, e.rd, e.data);
        end
      end
    end
  end

  task automatic send(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                      input logic [31:0] val, input logic [2:0] f3, input logic [1:0] off,
                      input int kind, input logic [31:0] exp_data);
    bit   accepted;
    exp_t e;
    in_valid   = 1'b1;
    in_rd      = rd;
    in_rd_we   = we;
    in_wb_sel  = sel;
    in_alu     = val;
    in_pc4     = val;
    in_ld_data = val;
    in_ld_f3   = f3;
    in_ld_off  = off;
    accepted   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) begin
      if (kind != K_SILENT) begin
        e.is_err = (kind == K_ERR);
        e.rd     = rd;
        e.data   = exp_data;
        sb.push_back(e);
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=%b want 1 within 40 cycles", in_ready);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (reg_wr !== 1'b0 || dir_wr !== 5'd0 || di !== 32'd0 || err_load !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got wr=%b rd=%0d di=%h err=%b rdy=%b want 0 0 0 0 1",
               reg_wr, dir_wr, di, err_load, in_ready);
    end
`ifdef WB_INSTRET_EN
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_instret got %0d want 0", instret);
    end
`endif
  endtask

  task automatic test_lw;
    @(negedge clk);
    send(5'd5, 1'b1, 2'b01, 32'hDEADBEEF, 3'b010, 2'd0, K_WRITE, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (reg_wr !== 1'b1 || dir_wr !== 5'd5 || di !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_latency got wr=%b rd=%0d di=%h want 1 5 deadbeef", reg_wr, dir_wr, di);
    end
    @(negedge clk);
    checks++;
    if (reg_wr !== 1'b0 || dir_wr !== 5'd5 || di !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_one_cycle got wr=%b rd=%0d di=%h want 0 5 deadbeef", reg_wr, dir_wr, di);
    end
  endtask

  task automatic test_load_extend;
    @(negedge clk);
    send(5'd7, 1'b1, 2'b01, 32'h80FF0000, 3'b000, 2'd3, K_WRITE, 32'hFFFFFF80);
    send(5'd7, 1'b1, 2'b01, 32'h80FF0000, 3'b100, 2'd3, K_WRITE, 32'h00000080);
    send(5'd7, 1'b1, 2'b01, 32'h80FF0000, 3'b101, 2'd2, K_WRITE, 32'h000080FF);
    send(5'd8, 1'b1, 2'b01, 32'h80FF0000, 3'b001, 2'd2, K_WRITE, 32'hFFFF80FF);
    send(5'd9, 1'b1, 2'b01, 32'h12348001, 3'b001, 2'd0, K_WRITE, 32'hFFFF8001);
    send(5'd10, 1'b1, 2'b01, 32'h12345678, 3'b000, 2'd1, K_WRITE, 32'h00000056);
    send(5'd11, 1'b1, 2'b10, 32'h00001004, 3'b000, 2'd0, K_WRITE, 32'h00001004);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_misaligned;
`ifdef WB_INSTRET_EN
    ir_snap = instret;
`endif
    @(negedge clk);
    send(5'd4, 1'b1, 2'b01, 32'hCAFEF00D, 3'b001, 2'd1, K_ERR, 32'd0);
    @(negedge clk);
    checks++;
    if (err_load !== 1'b1 || reg_wr !== 1'b0) begin
      errors++;
      $display("FAIL lh_misaligned got err=%b wr=%b want 1 0", err_load, reg_wr);
    end
    @(negedge clk);
    checks++;
    if (err_load !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle got err=%b want 0", err_load);
    end
    send(5'd4, 1'b1, 2'b01, 32'hCAFEF00D, 3'b010, 2'd2, K_ERR, 32'd0);
    send(5'd4, 1'b1, 2'b01, 32'hCAFEF00D, 3'b011, 2'd0, K_ERR, 32'd0);
    repeat (3) @(negedge clk);
`ifdef WB_INSTRET_EN
    checks++;
    if (instret !== ir_snap) begin
      errors++;
      $display("FAIL err_instret got %0d want %0d", instret, ir_snap);
    end
`endif
  endtask

  task automatic test_hold;
    logic [4:0]  wr_rd [4];
    logic [31:0] wr_di [4];
    logic        wr_en [4];
    @(negedge clk);
    hold = 1'b1;
    send(5'd1, 1'b1, 2'b00, 32'h11, 3'b000, 2'd0, K_WRITE, 32'h11);
    @(negedge clk);
    send(5'd2, 1'b1, 2'b00, 32'h22, 3'b000, 2'd0, K_WRITE, 32'h22);
    @(negedge clk);
    fork
      send(5'd3, 1'b1, 2'b00, 32'h33, 3'b000, 2'd0, K_WRITE, 32'h33);
      begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_full got in_ready=%b want 0", in_ready);
        end
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (reg_wr !== 1'b0 || err_load !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_quiet got wr=%b err=%b rdy=%b want 0 0 0", reg_wr, err_load, in_ready);
          end
        end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          wr_en[i] = reg_wr;
          wr_rd[i] = dir_wr;
          wr_di[i] = di;
        end
      end
    join
    for (int i = 0; i < 3; i++) begin
      logic [4:0]  erd;
      logic [31:0] edat;
      erd  = 5'(i + 1);
      edat = 32'(8'h11 * (i + 1));
      checks++;
      if (wr_en[i] !== 1'b1 || wr_rd[i] !== erd || wr_di[i] !== edat) begin
        errors++;
        $display("FAIL hold_order[%0d] got wr=%b rd=%0d di=%h want 1 %0d %h",
                 i, wr_en[i], wr_rd[i], wr_di[i], erd, edat);
      end
    end
    checks++;
    if (wr_en[3] !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain_end got wr=%b want 0", wr_en[3]);
    end
  endtask

  task automatic test_x0;
`ifdef WB_INSTRET_EN
    ir_snap = instret;
`endif
    @(negedge clk);
    send(5'd0, 1'b1, 2'b00, 32'h1234, 3'b000, 2'd0, K_SILENT, 32'd0);
    @(negedge clk);
    checks++;
    if (reg_wr !== 1'b0) begin
      errors++;
      $display("FAIL x0_write got reg_wr=%b want 0", reg_wr);
    end
`ifdef WB_INSTRET_EN
    checks++;
    if (instret !== ir_snap + 64'd1) begin
      errors++;
      $display("FAIL x0_instret got %0d want %0d", instret, ir_snap + 64'd1);
    end
`endif
    send(5'd12, 1'b0, 2'b00, 32'h5555, 3'b000, 2'd0, K_SILENT, 32'd0);
    send(5'd13, 1'b1, 2'b11, 32'h6666, 3'b000, 2'd0, K_SILENT, 32'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (dir_wr !== 5'd3 || di !== 32'h33) begin
      errors++;
      $display("FAIL silent_hold_value got rd=%0d di=%h want 3 00000033", dir_wr, di);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = $urandom;
      send(5'(20 + i), 1'b1, 2'b00, v, 3'b000, 2'd0, K_WRITE, v);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    hold = 1'b1;
    send(5'd14, 1'b1, 2'b00, 32'hAAAA, 3'b000, 2'd0, K_WRITE, 32'hAAAA);
    send(5'd15, 1'b1, 2'b00, 32'hBBBB, 3'b000, 2'd0, K_WRITE, 32'hBBBB);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (reg_wr !== 1'b0 || dir_wr !== 5'd0 || di !== 32'd0 || err_load !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got wr=%b rd=%0d di=%h err=%b want 0 0 0 0",
               reg_wr, dir_wr, di, err_load);
    end
    @(negedge clk);
    hold  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (reg_wr !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset got wr=%b rdy=%b want 0 1", reg_wr, in_ready);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    hold       = 1'b0;
    in_valid   = 1'b0;
    in_rd      = 5'd0;
    in_rd_we   = 1'b0;
    in_wb_sel  = 2'b00;
    in_alu     = 32'd0;
    in_pc4     = 32'd0;
    in_ld_data = 32'd0;
    in_ld_f3   = 3'b000;
    in_ld_off  = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_lw();
    test_load_extend();
    test_misaligned();
    test_hold();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RISC-V core. It sits between the memory stage and the register bank.
- It accepts retiring instructions through a valid/ready handshake and selects the result: ALU, load data, or PC+4.
- It aligns and sign/zero-extends load data and suppresses writes to x0.
- It drives the register bank write port (REG_WR, DIR_WR, DI) for exactly one cycle per retired instruction.
- A 2-entry buffer absorbs back-pressure while the external `hold` input (debug halt) is asserted.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- FIFO_DEPTH, 2, number of entries in the buffer. Must be at least 2.
- INSTRET_W, 64, width of the retire counter. Applies only with the optional feature.

Ports:
- clk  in  1  core clock. Everything is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept. Equals (count < FIFO_DEPTH) from registered count.
- in_rd  in  5  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_wb_sel  in  2  result source: 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved (treated as no write).
- in_alu  in  XLEN  ALU result.
- in_pc4  in  XLEN  PC+4.
- in_ld_data  in  XLEN  raw aligned memory word.
- in_ld_f3  in  3  load funct3.
- in_ld_off  in  2  byte offset of the load address.
- hold  in  1  freeze write-back. The buffer still fills.
- reg_wr  out  1  register bank write enable.
- dir_wr  out  5  register bank write address.
- di  out  XLEN  register bank write data.
- err_load  out  1  one-cycle pulse when a load is misaligned or has an illegal funct3.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - buffer empty, count = 0;
  - reg_wr = 0, dir_wr = 0, di = 0, err_load = 0;
  - in_ready = 1 from the first cycle after release.
- Accept: an entry is accepted on a rising edge where in_valid = 1 and in_ready = 1. The result is resolved at accept time, so the buffer stores {rd, we, data, err}.
- Load extraction for in_wb_sel = 01:
  - funct3 000 (LB) / 100 (LBU): byte at in_ld_off, sign- or zero-extended.
  - 001 (LH) / 101 (LHU): halfword at offset 0 or 2, sign- or zero-extended.
  - 010 (LW): offset must be 0.
  - LH/LHU with an odd offset, LW with offset ≠ 0, or any other funct3 sets err.
- Issue: on each edge where hold = 0 and an entry is available (buffer head, or the incoming entry when the buffer is empty), the output register loads it.
  - reg_wr = we & ~err & (rd ≠ 0), with dir_wr = rd and di = data.
  - err_load = err.
  - Latency: accepted at edge N gives reg_wr high during cycle N+1 when the buffer is empty and hold = 0.
- reg_wr, dir_wr, di and err_load are registered outputs. reg_wr and err_load are high for exactly one cycle per entry. dir_wr and di hold their last value when reg_wr = 0.
- While hold = 1:
  - reg_wr = 0 and err_load = 0;
  - accepts continue until count = FIFO_DEPTH, then in_ready = 0.
- Simultaneous push and pop on one edge: count is unchanged and order is preserved.
- In-order: entries issue strictly in acceptance order.
- x0: rd = 0 or we = 0 never asserts reg_wr, but the entry still retires.
- Reserved wb_sel 11: data = 0, no write, no error.
- Reset mid-operation: all buffered entries are discarded and no write is issued.

Optional Feature:
- Macro: WB_INSTRET_EN.
- When defined:
  - adds output port instret [INSTRET_W-1:0], reset to 0;
  - instret increments by 1 on each issue edge of an entry with err = 0, including x0 and no-write entries;
  - instret wraps modulo 2^INSTRET_W.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package riscv_wb_pkg holds:
  - XLEN;
  - the wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4);
  - the load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - a load_align function returning {data, err}.
- Sub-module wb_skid_fifo: a parameterised FIFO_DEPTH buffer with push/pop/count and pass-through when empty.

Test Plan:
- LW: wb_sel 01, f3 010, off 0, ld 0xDEADBEEF, rd 5, hold 0 → the cycle after accept, reg_wr = 1, dir_wr = 5, di = 0xDEADBEEF for one cycle.
- LB and LBU, off 3, ld 0x80FF0000, rd 7:
  - LB → di = 0xFFFFFF80;
  - LBU → di = 0x00000080;
  - LHU, off 2, same data → di = 0x000080FF.
- Misaligned loads:
  - LH off 1 → err_load pulses for 1 cycle, reg_wr = 0, instret unchanged;
  - LW off 2 → same.
- hold = 1 with 3 back-to-back valid ALU entries (rd 1/2/3, data 0x11/0x22/0x33):
  - third entry sees in_ready = 0 and stalls;
  - after hold drops, writes occur in order rd1, rd2, rd3 on consecutive cycles.
- rd = 0, wb_sel 00, alu 0x1234 → reg_wr stays 0 and instret increments by 1.
- Reset asserted with 2 entries buffered under hold:
  - all outputs go to 0 immediately;
  - no write occurs after release;
  - in_ready = 1.
